// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port (I) and a load/store port (D), with one transaction in flight and a completion timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    output logic        i_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_be_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state;
    logic        last_d;      // 1 when the most recent grant went to D
    logic [15:0] wait_cnt;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        can_grant;

    // On contention the port that did not win last time gets the grant, so the two
    // terms below are mutually exclusive.
    assign can_grant = (state == IDLE) && !reset_i;
    assign i_gnt_o   = can_grant && i_req_i && (!d_req_i || last_d);
    assign d_gnt_o   = can_grant && d_req_i && (!i_req_i || !last_d);

    assign mem_req_o   = (state != IDLE);
    assign mem_we_o    = cmd_we;
    assign mem_addr_o  = cmd_addr;
    assign mem_wdata_o = cmd_wdata;
    assign mem_be_o    = cmd_be;

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values of the others; blocking would chain updates within one edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            last_d     <= 1'b0;
            wait_cnt   <= '0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_be     <= '0;
            i_rvalid_o <= 1'b0;
            i_err_o    <= 1'b0;
            i_rdata_o  <= '0;
            d_rvalid_o <= 1'b0;
            d_err_o    <= 1'b0;
            d_rdata_o  <= '0;
        end else begin
            i_rvalid_o <= 1'b0;
            i_err_o    <= 1'b0;
            d_rvalid_o <= 1'b0;
            d_err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_gnt_o) begin
                        state     <= BUSY_I;
                        last_d    <= 1'b0;
                        wait_cnt  <= '0;
                        cmd_we    <= 1'b0;
                        cmd_addr  <= i_addr_i;
                        cmd_wdata <= '0;
                        cmd_be    <= 4'hF;
                    end else if (d_gnt_o) begin
                        state     <= BUSY_D;
                        last_d    <= 1'b1;
                        wait_cnt  <= '0;
                        cmd_we    <= d_we_i;
                        cmd_addr  <= d_addr_i;
                        cmd_wdata <= d_wdata_i;
                        cmd_be    <= d_be_i;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Ack wins over the timeout when both land in the same cycle.
                    if (mem_ack_i) begin
                        state <= IDLE;
                        if (state == BUSY_I) begin
                            i_rvalid_o <= 1'b1;
                            i_rdata_o  <= mem_rdata_i;
                        end else begin
                            d_rvalid_o <= 1'b1;
                            d_rdata_o  <= mem_rdata_i;
                        end
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        wait_cnt <= wait_cnt + 16'd1;
                        if (state == BUSY_I) begin
                            i_rvalid_o <= 1'b1;
                            i_err_o    <= 1'b1;
                            i_rdata_o  <= '0;
                        end else begin
                            d_rvalid_o <= 1'b1;
                            d_err_o    <= 1'b1;
                            d_rdata_o  <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, contention, timeout and its ack
// boundary, reset mid-transaction and stray acks, all against hand-computed values.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o, i_rvalid_o, i_err_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_store_cmd(input string tag);
        check({tag, "_req"},   {31'd0, mem_req_o}, 32'd1);
        check({tag, "_we"},    {31'd0, mem_we_o},  32'd1);
        check({tag, "_addr"},  mem_addr_o,         32'h0000_2004);
        check({tag, "_wdata"}, mem_wdata_o,        32'hDEAD_BEEF);
        check({tag, "_be"},    {28'd0, mem_be_o},  32'h3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq;
        int         n_gnt;
        int         busy;
        logic       seen;
        logic       cap_err;
        logic [31:0] cap_rdata;

        reset_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;

        // Reset state, grants suppressed while reset is held
        tick(); tick();
        i_req_i = 1'b1; d_req_i = 1'b1;
        #2;
        check("rst_i_gnt",   {31'd0, i_gnt_o},    32'd0);
        check("rst_d_gnt",   {31'd0, d_gnt_o},    32'd0);
        check("rst_mem_req", {31'd0, mem_req_o},  32'd0);
        check("rst_mem_be",  {28'd0, mem_be_o},   32'd0);
        check("rst_mem_adr", mem_addr_o,          32'd0);
        check("rst_rvalid",  {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
        check("rst_rdata",   i_rdata_o | d_rdata_o, 32'd0);

        // Single fetch, ack two cycles after mem_req rises
        tick();
        reset_i = 1'b0; d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h100;
        #2;
        check("f_i_gnt",   {31'd0, i_gnt_o},   32'd1);
        check("f_d_gnt",   {31'd0, d_gnt_o},   32'd0);
        check("f_req_c0",  {31'd0, mem_req_o}, 32'd0);
        tick();
        i_req_i = 1'b0; i_addr_i = 32'hFFFF_FFFF;
        #2;
        check("f_req_c1",  {31'd0, mem_req_o}, 32'd1);
        check("f_addr",    mem_addr_o,         32'h100);
        check("f_we",      {31'd0, mem_we_o},  32'd0);
        check("f_be",      {28'd0, mem_be_o},  32'hF);
        check("f_wdata",   mem_wdata_o,        32'd0);
        check("f_gnt_c1",  {31'd0, i_gnt_o},   32'd0);
        tick(); #2;
        check("f_req_c2",  {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0050_0093;
        #2;
        check("f_req_c3",  {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #2;
        check("f_req_c4",  {31'd0, mem_req_o},  32'd0);
        check("f_rvalid",  {31'd0, i_rvalid_o}, 32'd1);
        check("f_rdata",   i_rdata_o,           32'h0050_0093);
        check("f_err",     {31'd0, i_err_o},    32'd0);
        check("f_d_rvalid",{31'd0, d_rvalid_o}, 32'd0);
        tick(); #2;
        check("f_rvalid_c5", {31'd0, i_rvalid_o}, 32'd0);
        check("f_rdata_hold", i_rdata_o,          32'h0050_0093);

        // Store
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2004; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
        #2;
        check("s_d_gnt", {31'd0, d_gnt_o}, 32'd1);
        tick();
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h1; d_wdata_i = 32'h2; d_be_i = 4'hC;
        #2;
        check_store_cmd("s_c1");
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #2;
        check_store_cmd("s_c2");
        tick();
        mem_ack_i = 1'b0;
        #2;
        check("s_rvalid",   {31'd0, d_rvalid_o}, 32'd1);
        check("s_err",      {31'd0, d_err_o},    32'd0);
        check("s_rdata",    d_rdata_o,           32'h1234_5678);
        check("s_i_rvalid", {31'd0, i_rvalid_o}, 32'd0);
        check("s_req_done", {31'd0, mem_req_o},  32'd0);

        // Contention from reset release, one-cycle ack: expect D, I, D, I
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0; i_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0;
        i_addr_i = 32'h400; d_addr_i = 32'h800;
        seq = '0; n_gnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                tick();
                mem_ack_i = mem_req_o;
                mem_rdata_i = 32'hCAFE_0000 + c;
            end
            #2;
            check("c_both_gnt",    {31'd0, i_gnt_o & d_gnt_o},       32'd0);
            check("c_both_rvalid", {31'd0, i_rvalid_o & d_rvalid_o}, 32'd0);
            if (i_gnt_o || d_gnt_o) begin
                seq = {seq[2:0], d_gnt_o};
                n_gnt++;
            end
        end
        check("c_n_gnt", n_gnt,        32'd4);
        check("c_order", {28'd0, seq}, 32'hA);
        tick();
        mem_ack_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
        #2;
        check("c_last_rvalid", {31'd0, i_rvalid_o}, 32'd1);
        check("c_last_rdata",  i_rdata_o,           32'hCAFE_0007);
        check("c_d_rdata",     d_rdata_o,           32'hCAFE_0005);

        // Timeout with ack tied low
        d_req_i = 1'b1; d_addr_i = 32'h3000; mem_rdata_i = 32'hFFFF_FFFF;
        #2;
        check("t_d_gnt", {31'd0, d_gnt_o}, 32'd1);
        busy = 0; seen = 1'b0; cap_err = 1'b0; cap_rdata = 32'hDEAD_DEAD;
        for (int k = 0; k < 20; k++) begin
            tick();
            d_req_i = 1'b0;
            #2;
            if (mem_req_o) busy++;
            if (d_rvalid_o) begin
                seen = 1'b1; cap_err = d_err_o; cap_rdata = d_rdata_o;
                break;
            end
        end
        check("t_seen",  {31'd0, seen},    32'd1);
        check("t_busy",  busy,             32'd8);
        check("t_err",   {31'd0, cap_err}, 32'd1);
        check("t_rdata", cap_rdata,        32'd0);
        tick(); #2;
        check("t_rvalid_after", {31'd0, d_rvalid_o}, 32'd0);
        check("t_err_after",    {31'd0, d_err_o},    32'd0);

        // Ack in the cycle the counter reaches TIMEOUT completes normally
        i_req_i = 1'b1; i_addr_i = 32'h500;
        #2;
        check("b_i_gnt", {31'd0, i_gnt_o}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            i_req_i = 1'b0;
            mem_ack_i = (k == 8);
            mem_rdata_i = 32'h0BAD_F00D;
        end
        #2;
        check("b_req_c8", {31'd0, mem_req_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0;
        #2;
        check("b_rvalid", {31'd0, i_rvalid_o}, 32'd1);
        check("b_err",    {31'd0, i_err_o},    32'd0);
        check("b_rdata",  i_rdata_o,           32'h0BAD_F00D);

        // Reset during BUSY_D aborts with no response
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40;
        #2;
        check("r_d_gnt", {31'd0, d_gnt_o}, 32'd1);
        tick();
        d_req_i = 1'b0;
        tick();
        reset_i = 1'b1;
        #2;
        check("r_req_busy", {31'd0, mem_req_o}, 32'd1);
        tick(); #2;
        check("r_req_after", {31'd0, mem_req_o},  32'd0);
        check("r_no_rvalid", {31'd0, d_rvalid_o}, 32'd0);
        tick();
        reset_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #2;
        check("r_late_ack",  {31'd0, d_rvalid_o}, 32'd0);

        // Stray ack in IDLE: no response, state stays IDLE
        tick(); #2;
        check("sa_rvalid", {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
        check("sa_req",    {31'd0, mem_req_o},              32'd0);
        tick();
        mem_ack_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h600;
        #2;
        check("sa_rvalid2", {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
        check("sa_gnt",     {31'd0, i_gnt_o},               32'd1);
        tick();
        i_req_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
